pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Parametrised PLL lock supervisor and staged reset generator for the board clock domain.
- Drives the PLL asynchronous resets and synchronises up to NUM_PLL asynchronous lock inputs.
- Qualifies lock stability, then releases NUM_RST synchronous reset outputs one after another at fixed spacing.
- Recovers automatically from lock timeout or lock loss, and reports status counters.
- Sits between the external reset/100 MHz board clock and the HDMI/top PLL instances plus their downstream reset consumers.

## Interface
Parameters:
- NUM_PLL, default 2: number of PLL lock inputs (1..8).
- NUM_RST, default 3: number of staged reset outputs (1..8).
- SYNC_STAGES, default 2: synchroniser flops per lock input (2..4).
- PLL_RST_CYC, default 16: cycles `pll_areset` is held high per attempt.
- LOCK_STABLE_CYC, default 1024: consecutive all-locked cycles required.
- STAGE_GAP_CYC, default 256: cycles between successive `srst` releases.
- LOCK_TIMEOUT_CYC, default 20000: cycles allowed in WAIT_LOCK before retry.
- CNT_W, default 8: width of the status counters.

Ports:
- `clk_in`  in  1: sole clock, board 100 MHz.
- `areset`  in  1: asynchronous, active-high reset.
- `pll_lock`  in  NUM_PLL: asynchronous lock flags from the PLLs.
- `pll_areset`  out  1: active-high reset to all PLLs.
- `srst`  out  NUM_RST: active-high synchronous resets; bit 0 is released first.
- `all_ready`  out  1: high only in RUN.
- `timeout`  out  1: sticky; set on the first lock timeout, cleared only by `areset`.
- `retry_cnt`  out  CNT_W: saturating count of timeouts.
- `loss_cnt`  out  CNT_W: saturating count of lock-loss events.

## Operation
- Lock synchronisation: each `pll_lock` bit passes through SYNC_STAGES flops to give `lock_s`. `lock_all` = AND of all `lock_s` bits.
- **RESET_PLL**
  - `pll_areset`=1 and `srst`=all ones.
  - The counter runs 0..PLL_RST_CYC-1, then the FSM goes to WAIT_LOCK.
- **WAIT_LOCK**
  - `pll_areset`=0 and `srst`=all ones.
  - The stable counter increments while `lock_all`=1 and clears to 0 whenever `lock_all`=0.
  - The timeout counter increments every cycle.
  - Stable counter reaching LOCK_STABLE_CYC: go to RELEASE with index 0.
  - Otherwise, timeout counter reaching LOCK_TIMEOUT_CYC: set `timeout`, increment `retry_cnt`, go to RESET_PLL.
  - If both happen in the same cycle, RELEASE wins.
- **RELEASE**
  - On entry, `srst[0]` is released.
  - Each subsequent bit i is released STAGE_GAP_CYC cycles after bit i-1.
  - Once released, a bit stays low until an abort.
  - The cycle after `srst[NUM_RST-1]` is released, the FSM goes to RUN.
- **RUN**: `all_ready`=1 and `srst`=all zeros.
- **Lock loss** (`lock_all`=0 while in RELEASE or RUN):
  - Next cycle, all `srst` bits are 1 and `all_ready`=0.
  - `loss_cnt` increments.
  - The FSM enters RESET_PLL with all counters cleared.
- **Counters**: `retry_cnt` and `loss_cnt` saturate at 2^CNT_W-1 and never wrap.
- **`areset` mid-operation**: immediately forces the reset values below, regardless of state.

## Timing
- Reset values while `areset`=1:
  - `pll_areset`=1, `srst`=all ones, `all_ready`=0, `timeout`=0, `retry_cnt`=0, `loss_cnt`=0.
  - Synchronisers hold 0; FSM is in RESET_PLL; all counters are 0.
- All outputs are registered; no combinational path from any input to any output.
- `pll_areset` falls on edge PLL_RST_CYC after the first `clk_in` edge with `areset` low.
- Lock release latency:
  - Let T be the edge at which the last `pll_lock` bit is first sampled high, all bits staying high.
  - `srst[0]` is low after edge T + SYNC_STAGES + LOCK_STABLE_CYC.
  - `srst[i]` is low after `srst[0]`'s edge + i·STAGE_GAP_CYC.
  - `all_ready` rises one edge after `srst[NUM_RST-1]` falls.
- Lock-drop reaction: a `pll_lock` fall reaches `srst`=all ones after SYNC_STAGES+1 edges.
- Glitch rule: a lock pulse of fewer than LOCK_STABLE_CYC cycles during WAIT_LOCK never releases any `srst` bit.

## Test plan
Common settings: NUM_PLL=2, NUM_RST=3, SYNC_STAGES=2, PLL_RST_CYC=16, LOCK_STABLE_CYC=64, STAGE_GAP_CYC=8, LOCK_TIMEOUT_CYC=1000.

1. Nominal bring-up: `areset` released at edge 0; both locks rise at edge 100.
   - `pll_areset` falls at edge 16.
   - `srst` bits fall at edges 166, 174 and 182.
   - `all_ready` rises at edge 183; both counters stay 0.
2. Unstable lock: lock[1] toggles with a 40-cycle period starting at edge 50, then holds high from edge 300.
   - No `srst` release before edge 366.
   - `srst[0]` falls at edge 366.
3. Timeout retry: locks held 0.
   - At WAIT_LOCK cycle 1000, `timeout`=1 and `retry_cnt`=1, and `pll_areset` goes high for 16 cycles.
   - After 300 retries with locks still held 0, `retry_cnt`=255 (saturated).
4. Lock loss in RUN: after scenario 1, drop lock[0] for 1 cycle.
   - `srst`=3'b111 and `all_ready`=0 three edges later; `loss_cnt`=1.
   - `pll_areset` pulses for 16 cycles; sequencing then restarts and completes again.
5. Lock loss mid-RELEASE: drop lock[1] one cycle after `srst[0]` falls.
   - All `srst` bits return to 1; `srst[1]` and `srst[2]` are never released in that attempt; `loss_cnt`=1.
6. Async reset mid-RUN: assert `areset` between clock edges.
   - All outputs take their reset values before the next edge.
   - `timeout`, `retry_cnt` and `loss_cnt` are all cleared.

Source files
------------

// File: rtl/pll_reset_seq.sv
// PLL lock supervisor: holds the PLLs in reset, qualifies a stable lock on all of
// them, then releases the downstream synchronous resets one stage at a time.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_RESET_PLL | pll_areset high for PLL_RST_CYC cycles, all srst held
// S_WAIT_LOCK | PLLs running; wait for LOCK_STABLE_CYC clean lock cycles or timeout
// S_RELEASE   | srst bits dropped in order, STAGE_GAP_CYC apart
// S_RUN       | everything released, all_ready high

module pll_reset_seq #(
    parameter int NUM_PLL          = 2,
    parameter int NUM_RST          = 3,
    parameter int SYNC_STAGES      = 2,
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int STAGE_GAP_CYC    = 256,
    parameter int LOCK_TIMEOUT_CYC = 20000,
    parameter int CNT_W            = 8
) (
    input  logic               clk_in,
    input  logic               areset,
    input  logic [NUM_PLL-1:0] pll_lock,
    output logic               pll_areset,
    output logic [NUM_RST-1:0] srst,
    output logic               all_ready,
    output logic               timeout,
    output logic [CNT_W-1:0]   retry_cnt,
    output logic [CNT_W-1:0]   loss_cnt
);

    localparam int SEQ_MAX = (PLL_RST_CYC > STAGE_GAP_CYC) ? PLL_RST_CYC : STAGE_GAP_CYC;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int IDX_W   = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    typedef enum logic [1:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN
    } state_t;

    logic [NUM_PLL-1:0] sync_q [SYNC_STAGES];
    logic               lock_all;

    state_t             state_q, state_d;
    logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pll_areset_q, pll_areset_d;
    logic [NUM_RST-1:0] srst_q, srst_d;
    logic               all_ready_q, all_ready_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]   loss_q, loss_d;

    always_ff @(posedge clk_in or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pll_lock;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign lock_all = &sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d      = state_q;
        seq_cnt_d    = seq_cnt_q;
        stable_d     = stable_q;
        to_d         = to_q;
        idx_d        = idx_q;
        pll_areset_d = pll_areset_q;
        srst_d       = srst_q;
        all_ready_d  = 1'b0;
        timeout_d    = timeout_q;
        retry_d      = retry_q;
        loss_d       = loss_q;

        case (state_q)
            S_RESET_PLL: begin
                pll_areset_d = 1'b1;
                srst_d       = '1;
                if (seq_cnt_q == SEQ_W'(PLL_RST_CYC - 1)) begin
                    state_d      = S_WAIT_LOCK;
                    seq_cnt_d    = '0;
                    pll_areset_d = 1'b0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                pll_areset_d = 1'b0;
                srst_d       = '1;
                // Stability is judged on the registered count, so release always wins a tie
                if (stable_q == STB_W'(LOCK_STABLE_CYC)) begin
                    state_d   = S_RELEASE;
                    srst_d[0] = 1'b0;
                    idx_d     = '0;
                    seq_cnt_d = '0;
                    stable_d  = '0;
                    to_d      = '0;
                end else if (to_q == TO_W'(LOCK_TIMEOUT_CYC)) begin
                    state_d      = S_RESET_PLL;
                    pll_areset_d = 1'b1;
                    timeout_d    = 1'b1;
                    stable_d     = '0;
                    to_d         = '0;
                    if (retry_q != {CNT_W{1'b1}}) retry_d = retry_q + CNT_W'(1);
                end else begin
                    stable_d = lock_all ? stable_q + STB_W'(1) : '0;
                    to_d     = to_q + TO_W'(1);
                end
            end
            S_RELEASE: begin
                pll_areset_d = 1'b0;
                if (idx_q == IDX_W'(NUM_RST - 1)) begin
                    state_d     = S_RUN;
                    all_ready_d = 1'b1;
                    srst_d      = '0;
                end else if (seq_cnt_q == SEQ_W'(STAGE_GAP_CYC - 1)) begin
                    idx_d         = idx_q + IDX_W'(1);
                    srst_d[idx_d] = 1'b0;
                    seq_cnt_d     = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            S_RUN: begin
                pll_areset_d = 1'b0;
                srst_d       = '0;
                all_ready_d  = 1'b1;
            end
            default: state_d = S_RESET_PLL;
        endcase

        // Losing lock after release overrides whatever the state decided above
        if ((state_q == S_RELEASE || state_q == S_RUN) && !lock_all) begin
            state_d      = S_RESET_PLL;
            pll_areset_d = 1'b1;
            srst_d       = '1;
            all_ready_d  = 1'b0;
            seq_cnt_d    = '0;
            stable_d     = '0;
            to_d         = '0;
            idx_d        = '0;
            if (loss_q != {CNT_W{1'b1}}) loss_d = loss_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge areset) begin
        if (areset) begin
            state_q      <= S_RESET_PLL;
            seq_cnt_q    <= '0;
            stable_q     <= '0;
            to_q         <= '0;
            idx_q        <= '0;
            pll_areset_q <= 1'b1;
            srst_q       <= '1;
            all_ready_q  <= 1'b0;
            timeout_q    <= 1'b0;
            retry_q      <= '0;
            loss_q       <= '0;
        end else begin
            state_q      <= state_d;
            seq_cnt_q    <= seq_cnt_d;
            stable_q     <= stable_d;
            to_q         <= to_d;
            idx_q        <= idx_d;
            pll_areset_q <= pll_areset_d;
            srst_q       <= srst_d;
            all_ready_q  <= all_ready_d;
            timeout_q    <= timeout_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
        end
    end

    assign pll_areset = pll_areset_q;
    assign srst       = srst_q;
    assign all_ready  = all_ready_q;
    assign timeout    = timeout_q;
    assign retry_cnt  = retry_q;
    assign loss_cnt   = loss_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: timed expectations queued per scenario and checked at the
// matching clock edge; a second instance with short timers covers counter saturation.

module tb_pll_reset_seq;

    localparam int NUM_PLL = 2;
    localparam int NUM_RST = 3;
    localparam int CNT_W   = 8;

    localparam int SIG_PLL   = 0;
    localparam int SIG_SRST  = 1;
    localparam int SIG_READY = 2;
    localparam int SIG_TO    = 3;
    localparam int SIG_RETRY = 4;
    localparam int SIG_LOSS  = 5;
    localparam int SAT_RETRY = 6;
    localparam int SAT_TO    = 7;

    logic               clk_in = 1'b0;
    logic               areset;
    logic [NUM_PLL-1:0] pll_lock;
    logic               pll_areset;
    logic [NUM_RST-1:0] srst;
    logic               all_ready;
    logic               timeout;
    logic [CNT_W-1:0]   retry_cnt;
    logic [CNT_W-1:0]   loss_cnt;

    logic               areset_sat;
    logic [NUM_PLL-1:0] lock_sat;
    logic               pll_areset_sat;
    logic [NUM_RST-1:0] srst_sat;
    logic               all_ready_sat;
    logic               timeout_sat;
    logic [CNT_W-1:0]   retry_sat;
    logic [CNT_W-1:0]   loss_sat;

    pll_reset_seq #(
        .NUM_PLL(NUM_PLL), .NUM_RST(NUM_RST), .SYNC_STAGES(2), .PLL_RST_CYC(16),
        .LOCK_STABLE_CYC(64), .STAGE_GAP_CYC(8), .LOCK_TIMEOUT_CYC(1000), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .areset(areset), .pll_lock(pll_lock), .pll_areset(pll_areset),
        .srst(srst), .all_ready(all_ready), .timeout(timeout),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    pll_reset_seq #(
        .NUM_PLL(NUM_PLL), .NUM_RST(NUM_RST), .SYNC_STAGES(2), .PLL_RST_CYC(4),
        .LOCK_STABLE_CYC(64), .STAGE_GAP_CYC(8), .LOCK_TIMEOUT_CYC(20), .CNT_W(CNT_W)
    ) dut_sat (
        .clk_in(clk_in), .areset(areset_sat), .pll_lock(lock_sat), .pll_areset(pll_areset_sat),
        .srst(srst_sat), .all_ready(all_ready_sat), .timeout(timeout_sat),
        .retry_cnt(retry_sat), .loss_cnt(loss_sat)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          at;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  edge_n   = 0;
    int  base     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_sig(input int sel);
        case (sel)
            SIG_PLL:   return {31'b0, pll_areset};
            SIG_SRST:  return {29'b0, srst};
            SIG_READY: return {31'b0, all_ready};
            SIG_TO:    return {31'b0, timeout};
            SIG_RETRY: return {24'b0, retry_cnt};
            SIG_LOSS:  return {24'b0, loss_cnt};
            SAT_RETRY: return {24'b0, retry_sat};
            default:   return {31'b0, timeout_sat};
        endcase
    endfunction

    task automatic expect_abs(input int at, input int sel, input logic [31:0] exp, input string tag);
        sb.push_back('{at, sel, exp, tag});
    endtask

    task automatic expect_at(input int rel, input int sel, input logic [31:0] exp, input string tag);
        expect_abs(base + rel, sel, exp, $sformatf("%s @%0d", tag, rel));
    endtask

    task automatic drain();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == edge_n) begin
                chk(sb[i].tag, get_sig(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end else if (sb[i].at < edge_n) begin
                chk({sb[i].tag, " missed edge"}, edge_n, sb[i].at);
                sb.delete(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        edge_n++;
        @(negedge clk_in);
        drain();
    endtask

    task automatic run_to(input int rel);
        while (edge_n < base + rel) tick();
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, " pll_areset"}, {31'b0, pll_areset}, 32'd1);
        chk({pfx, " srst"}, {29'b0, srst}, 32'd7);
        chk({pfx, " all_ready"}, {31'b0, all_ready}, 32'd0);
        chk({pfx, " timeout"}, {31'b0, timeout}, 32'd0);
        chk({pfx, " retry_cnt"}, {24'b0, retry_cnt}, 32'd0);
        chk({pfx, " loss_cnt"}, {24'b0, loss_cnt}, 32'd0);
    endtask

    // areset is released just after edge 0 of the scenario; edge 1 is the first clean edge
    task automatic do_reset(input logic [NUM_PLL-1:0] lock_init, input string pfx);
        pll_lock = lock_init;
        areset   = 1'b1;
        #1;
        chk_reset_vals(pfx);
        tick();
        tick();
        areset = 1'b0;
        base   = edge_n;
        if (areset_sat) begin
            areset_sat = 1'b0;
            expect_abs(base + 24,   SAT_RETRY, 32'd0,   "sat retry before first timeout");
            expect_abs(base + 25,   SAT_RETRY, 32'd1,   "sat retry first timeout");
            expect_abs(base + 25,   SAT_TO,    32'd1,   "sat timeout sticky set");
            expect_abs(base + 6374, SAT_RETRY, 32'd254, "sat retry 254");
            expect_abs(base + 6375, SAT_RETRY, 32'd255, "sat retry 255");
            expect_abs(base + 7600, SAT_RETRY, 32'd255, "sat retry held after 300");
            expect_abs(base + 7600, SAT_TO,    32'd1,   "sat timeout still set");
        end
    endtask

    function automatic logic lock1_pat(input int e);
        return (e >= 300) || (e >= 50 && e < 290 && ((e - 50) % 40) < 20);
    endfunction

    task automatic expect_bringup(input int r0, input string pfx);
        expect_at(r0 - 1,  SIG_SRST,  32'd7, {pfx, " srst held"});
        expect_at(r0,      SIG_SRST,  32'd6, {pfx, " srst0 released"});
        expect_at(r0 + 7,  SIG_SRST,  32'd6, {pfx, " srst1 held"});
        expect_at(r0 + 8,  SIG_SRST,  32'd4, {pfx, " srst1 released"});
        expect_at(r0 + 15, SIG_SRST,  32'd4, {pfx, " srst2 held"});
        expect_at(r0 + 16, SIG_SRST,  32'd0, {pfx, " srst2 released"});
        expect_at(r0 + 16, SIG_READY, 32'd0, {pfx, " ready low"});
        expect_at(r0 + 17, SIG_READY, 32'd1, {pfx, " ready high"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        areset     = 1'b0;
        areset_sat = 1'b0;
        pll_lock   = '0;
        lock_sat   = '0;
        #1;
        areset_sat = 1'b1;

        // nominal bring-up
        do_reset(2'b00, "s1 reset");
        expect_at(15, SIG_PLL, 32'd1, "s1 pll_areset held");
        expect_at(16, SIG_PLL, 32'd0, "s1 pll_areset falls");
        expect_bringup(166, "s1");
        expect_at(183, SIG_RETRY, 32'd0, "s1 retry_cnt");
        expect_at(183, SIG_LOSS,  32'd0, "s1 loss_cnt");
        expect_at(183, SIG_TO,    32'd0, "s1 timeout");
        run_to(99);
        pll_lock = 2'b11;
        run_to(199);

        // lock loss in RUN: lock[0] low for the single edge 200
        expect_at(201, SIG_SRST,  32'd0, "s4 srst before reaction");
        expect_at(201, SIG_READY, 32'd1, "s4 ready before reaction");
        expect_at(202, SIG_SRST,  32'd7, "s4 srst reasserted");
        expect_at(202, SIG_READY, 32'd0, "s4 ready dropped");
        expect_at(202, SIG_LOSS,  32'd1, "s4 loss_cnt");
        expect_at(202, SIG_PLL,   32'd1, "s4 pll_areset rises");
        expect_at(217, SIG_PLL,   32'd1, "s4 pll_areset held");
        expect_at(218, SIG_PLL,   32'd0, "s4 pll_areset falls");
        expect_bringup(283, "s4");
        expect_at(300, SIG_LOSS,  32'd1, "s4 loss_cnt kept");
        pll_lock = 2'b10;
        tick();
        pll_lock = 2'b11;
        run_to(305);

        // unstable lock[1]: short pulses, then steadily high from edge 300
        do_reset(2'b00, "s2 reset");
        for (int e = 17; e <= 365; e++) expect_at(e, SIG_SRST, 32'd7, "s2 srst held");
        expect_at(366, SIG_SRST, 32'd6, "s2 srst0 released");
        expect_at(366, SIG_TO,   32'd0, "s2 timeout");
        for (int e = 1; e <= 370; e++) begin
            pll_lock = {lock1_pat(e), 1'b1};
            tick();
        end

        // lock loss one cycle into RELEASE
        do_reset(2'b11, "s5 reset");
        expect_at(81, SIG_SRST, 32'd6, "s5 srst0 released");
        expect_at(83, SIG_SRST, 32'd6, "s5 srst before reaction");
        for (int e = 84; e <= 164; e++) expect_at(e, SIG_SRST, 32'd7, "s5 srst aborted");
        expect_at(84,  SIG_LOSS, 32'd1, "s5 loss_cnt");
        expect_at(100, SIG_PLL,  32'd0, "s5 pll_areset falls");
        expect_bringup(165, "s5 retry");
        run_to(81);
        pll_lock = 2'b01;
        tick();
        pll_lock = 2'b11;
        run_to(185);

        // lock timeout, then lock arrives after the retry
        do_reset(2'b00, "s3 reset");
        expect_at(1016, SIG_TO,    32'd0, "s3 timeout before");
        expect_at(1016, SIG_RETRY, 32'd0, "s3 retry before");
        expect_at(1016, SIG_PLL,   32'd0, "s3 pll_areset before");
        expect_at(1017, SIG_TO,    32'd1, "s3 timeout set");
        expect_at(1017, SIG_RETRY, 32'd1, "s3 retry_cnt");
        expect_at(1017, SIG_PLL,   32'd1, "s3 pll_areset retry");
        expect_at(1032, SIG_PLL,   32'd1, "s3 pll_areset held");
        expect_at(1033, SIG_PLL,   32'd0, "s3 pll_areset falls");
        expect_at(1033, SIG_TO,    32'd1, "s3 timeout sticky");
        expect_bringup(1106, "s3");
        expect_at(1123, SIG_TO,    32'd1, "s3 timeout in run");
        expect_at(1123, SIG_RETRY, 32'd1, "s3 retry in run");
        run_to(1039);
        pll_lock = 2'b11;
        run_to(1130);

        // asynchronous reset between edges while running
        #2;
        areset = 1'b1;
        #1;
        chk_reset_vals("s6 async");

        guard = 0;
        while (sb.size() > 0 && guard < 20000) begin
            tick();
            guard++;
        end
        if (sb.size() > 0) chk("scoreboard drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
